mem_ctrl_mem: RTL and testbench
===============================

Name: mem_ctrl_mem

Overview:
Data-memory access controller in the MEM stage. It consumes the active-low ctrl_MEM bundle {MEM_RD, MEM_WR, w_h} produced by the control path, together with the ALU address and the store data. It runs a req/ack transaction on the external data-memory bus and stalls the pipeline until the access completes. For lw it returns read data to the WB mux.

Parameters:
ADDR_W, 10, word-address width on the memory bus (byte address bits [ADDR_W+1:2])
TIMEOUT, 16, cycles to wait in REQ for mem_ack before aborting; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
ctrl_MEM  in  3  {MEM_RD, MEM_WR, w_h}; MEM_RD/MEM_WR active-low; w_h 1=word, 0=halfword
alu_res  in  32  byte address from EXE/MEM pipe
dato_wr  in  32  store data (rt)
mem_req  out  1  bus request, held until ack
mem_we  out  1  1=write, 0=read
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  positioned write data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion strobe
dato_rd  out  32  registered load result
stall  out  1  freeze IF/ID/EXE/MEM pipes
err_timeout  out  1  one-cycle pulse on aborted access
err_align  out  1  one-cycle pulse on misaligned access (0 unless MEM_ALIGN_CHK_EN)

Behaviour:
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, dato_rd=0, err_*=0, timeout counter=0. stall is combinational and reads 0 in reset.
- cmd = (MEM_RD==0) | (MEM_WR==0). If both are 0, the read wins and the write is dropped.
- FSM states: IDLE, REQ, DONE.
- IDLE: ack is ignored. If cmd is set, latch the address, type and data, then go to REQ next edge. stall=1 combinationally in this cycle.
- REQ: mem_req=1 and all bus outputs stay stable. stall=1. The counter increments each cycle.
  - On mem_ack=1: for a read, dato_rd <= mem_rdata. Go to DONE.
  - If the counter reaches TIMEOUT-1 without ack (TIMEOUT>0): drop mem_req, set dato_rd=0, pulse err_timeout, go to DONE.
- DONE: stall=0 and ack is ignored. The pipe advances this cycle; always return to IDLE with no relaunch.
- stall = (IDLE & cmd) | REQ.
- Minimum latency is 3 cycles (cmd, REQ with immediate ack, DONE). Each extra wait cycle before ack adds 1.
- Encoding:
  - Read: we=0, be=1111.
  - Word store: be=1111, wdata=dato_wr.
  - Half store, addr[1]=0: be=0011, wdata={16'h0,dato_wr[15:0]}.
  - Half store, addr[1]=1: be=1100, wdata={dato_wr[15:0],16'h0}.
- mem_addr = alu_res[ADDR_W+1:2]. Upper bits are discarded.
- Async reset mid-transaction: mem_req drops immediately, FSM goes to IDLE, and the pending access is lost.
- No-op instructions (both controls 1): no bus activity, stall=0.

Optional Feature:
MEM_ALIGN_CHK_EN
- Defined: a misaligned access is detected in IDLE. Misaligned means word with addr[1:0]!=0, or half with addr[0]!=0. On detection there is no bus request, err_align pulses for 1 cycle, FSM goes directly to DONE, and dato_rd is unchanged. The result is one stall cycle.
- Undefined: low address bits are ignored as in the encoding rules, and err_align is tied to 0.

Test Plan:
- lw: ctrl_MEM=3'b011, alu_res=0x0000_0010, ack 2 cycles after req with rdata=0xCAFE_F00D -> mem_addr=4, we=0, be=1111; stall high 4 cycles; dato_rd=0xCAFE_F00D in DONE.
- sw then sh: sw (3'b101) addr 0x8, data 0x1234_5678 -> be=1111, wdata=0x1234_5678. Then sh (3'b100) addr 0xA, data 0xAAAA_BBBB -> be=1100, wdata=0xBBBB_0000, mem_addr=2.
- Timeout: TIMEOUT=4, lw, ack never arrives -> mem_req high exactly 4 cycles; err_timeout pulses once; dato_rd=0; stall drops in DONE.
- Async reset mid-REQ: drop reset_n while mem_req=1 -> mem_req=0 and stall=0 immediately; a subsequent lw completes normally.
- Conflict/no-op: ctrl_MEM=3'b001 -> read performed, we=0; ctrl_MEM=3'b111 -> no mem_req, stall=0; a stray mem_ack in IDLE causes no change.
- With MEM_ALIGN_CHK_EN: sw addr 0x6 -> no mem_req, err_align=1 for 1 cycle, stall 1 cycle; without the macro -> be=1111, mem_addr=1.

Source files
------------

// File: rtl/mem_ctrl_mem.sv
// mem_ctrl_mem: MEM-stage data-memory access controller.
// Decodes the active-low {MEM_RD, MEM_WR, w_h} bundle and runs one req/ack
// transaction per access on the data-memory bus. It stalls the pipeline until
// the access completes and returns load data to the WB mux.
//
// Optional feature macro: MEM_ALIGN_CHK_EN. When defined, misaligned accesses
// are rejected without a bus request and err_align pulses. When undefined,
// err_align stays 0.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   ctrl_MEM[2:0]            {MEM_RD_n, MEM_WR_n, w_h}; w_h 1=word 0=half
//   alu_res[31:0]            byte address
//   dato_wr[31:0]            store data
//   mem_req/we/be/addr/wdata bus request side (registered)
//   mem_rdata, mem_ack       bus response side
//   dato_rd[31:0]            registered load result
//   stall                    combinational pipeline freeze
//   err_timeout, err_align   one-cycle error pulses
module mem_ctrl_mem #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        ctrl_MEM,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       dato_wr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       dato_rd,
  output logic              stall,
  output logic              err_timeout,
  output logic              err_align
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_q;
  logic              rd_pend_q;
  logic              err_to_q;
  logic              err_al_q;
  logic [CNT_W-1:0]  cnt_q;

  // Control decode; a simultaneous read and write performs only the read.
  logic rd_c, wr_c, word_c, cmd_c, misalign_c;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  assign rd_c   = ~ctrl_MEM[2];
  assign wr_c   = ~ctrl_MEM[1];
  assign word_c = ctrl_MEM[0];
  assign cmd_c  = rd_c | wr_c;

`ifdef MEM_ALIGN_CHK_EN
  assign misalign_c = word_c ? (alu_res[1:0] != 2'b00) : alu_res[0];
  logic unused_c;
  assign unused_c = ^alu_res[31:ADDR_W+2];
`else
  assign misalign_c = 1'b0;
  logic unused_c;
  assign unused_c = ^{alu_res[31:ADDR_W+2], alu_res[0]};
`endif

  // Byte lanes and write-data positioning; halfwords select lane pair by addr[1].
  always_comb begin
    be_d    = 4'hF;
    wdata_d = dato_wr;
    if (!rd_c && !word_c) begin
      if (alu_res[1]) begin
        be_d    = 4'hC;
        wdata_d = {dato_wr[15:0], 16'h0000};
      end else begin
        be_d    = 4'h3;
        wdata_d = {16'h0000, dato_wr[15:0]};
      end
    end
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      rd_q      <= 32'h0;
      rd_pend_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_al_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      err_to_q <= 1'b0;
      err_al_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_c && misalign_c) begin
            err_al_q <= 1'b1;
            state_q  <= DONE;
          end else if (cmd_c) begin
            req_q     <= 1'b1;
            we_q      <= ~rd_c;
            be_q      <= be_d;
            addr_q    <= alu_res[ADDR_W+1:2];
            wdata_q   <= wdata_d;
            rd_pend_q <= rd_c;
            cnt_q     <= '0;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (rd_pend_q) rd_q <= mem_rdata;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            req_q    <= 1'b0;
            rd_q     <= 32'h0;
            err_to_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset gates stall so an aborted access releases the pipe immediately.
  assign stall = reset_n & (((state_q == IDLE) & cmd_c) | (state_q == REQ));

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_be      = be_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign dato_rd     = rd_q;
  assign err_timeout = err_to_q;
  assign err_align   = err_al_q;

endmodule

// File: tb/tb_mem_ctrl_mem.sv
// Scoreboard bench for mem_ctrl_mem: the stimulus pushes expected bus requests
// and completion results, and a negedge monitor pops and compares them when
// mem_req rises or when stall falls.
module tb_mem_ctrl_mem;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        ctrl_MEM = 3'b111;
  logic [31:0]       alu_res = 32'h0;
  logic [31:0]       dato_wr = 32'h0;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;
  logic              mem_ack = 1'b0;
  logic [31:0]       dato_rd;
  logic              stall, err_timeout, err_align;

  always #5 clk = ~clk;

  mem_ctrl_mem #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_MEM(ctrl_MEM), .alu_res(alu_res),
    .dato_wr(dato_wr), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .dato_rd(dato_rd), .stall(stall),
    .err_timeout(err_timeout), .err_align(err_align)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        to;
    logic        al;
    int          st_n;
    int          rq_n;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: acks on the ack_at-th request cycle (0 = never).
  int          ack_at = 0;
  int          req_cyc = 0;
  logic        stray = 1'b0;
  logic [31:0] rdata_v = 32'h0;
  always @(posedge clk) begin
    #2;
    if (mem_req) req_cyc++;
    else req_cyc = 0;
    mem_ack   = stray | (mem_req && ack_at != 0 && req_cyc == ack_at);
    mem_rdata = mem_ack ? rdata_v : 32'h0;
  end

  // Monitor.
  int        st_n = 0, rq_n = 0, to_cnt = 0, al_cnt = 0;
  logic      prev_st = 1'b0, prev_rq = 1'b0;
  bus_exp_t  mb;
  done_exp_t md;
  always @(negedge clk) begin
    if (!reset_n) begin
      st_n = 0; rq_n = 0; prev_st = 1'b0; prev_rq = 1'b0;
    end else begin
      if (mem_req && !prev_rq) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h with no request expected", mem_addr);
        end else begin
          mb = bus_q.pop_front();
          chk("bus_addr", 32'(mem_addr), 32'(mb.addr));
          chk("bus_we", 32'(mem_we), 32'(mb.we));
          chk("bus_be", 32'(mem_be), 32'(mb.be));
          if (mb.we) chk("bus_wdata", mem_wdata, mb.wdata);
        end
      end
      if (stall) st_n++;
      if (mem_req) rq_n++;
      if (err_timeout) to_cnt++;
      if (err_align) al_cnt++;
      if (prev_st && !stall) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got stall release with no access expected");
        end else begin
          md = done_q.pop_front();
          chk("dato_rd", dato_rd, md.rd);
          chk("err_timeout", 32'(err_timeout), 32'(md.to));
          chk("err_align", 32'(err_align), 32'(md.al));
          chk("stall_cycles", 32'(st_n), 32'(md.st_n));
          chk("req_cycles", 32'(rq_n), 32'(md.rq_n));
        end
        st_n = 0; rq_n = 0;
      end
      prev_st = stall;
      prev_rq = mem_req;
    end
  end

  task automatic access(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data,
                        input int ack_n, input logic [31:0] rdat, input logic bus_exp,
                        input logic [ADDR_W-1:0] e_addr, input logic e_we, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_rd, input logic e_to,
                        input logic e_al, input int e_st, input int e_rq);
    bus_exp_t  b;
    done_exp_t d;
    int n;
    @(posedge clk); #1;
    if (bus_exp) begin
      b.addr = e_addr; b.we = e_we; b.be = e_be; b.wdata = e_wdata;
      bus_q.push_back(b);
    end
    d.rd = e_rd; d.to = e_to; d.al = e_al; d.st_n = e_st; d.rq_n = e_rq;
    done_q.push_back(d);
    ack_at = ack_n; rdata_v = rdat;
    ctrl_MEM = ctrl; alu_res = addr; dato_wr = data;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (stall && n < 64);
    if (stall) begin
      checks++; errors++;
      $display("FAIL access_timeout: got stall still high after %0d cycles, required release", n);
    end
    ctrl_MEM = 3'b111;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_dato_rd", dato_rd, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_err", 32'({err_timeout, err_align}), 32'h0);
    reset_n = 1'b1;

    // lw, ack on 3rd request cycle.
    access(3'b011, 32'h0000_0010, 32'h0, 3, 32'hCAFE_F00D, 1'b1,
           10'd4, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 4, 3);
    // sw word.
    access(3'b101, 32'h0000_0008, 32'h1234_5678, 1, 32'h0, 1'b1,
           10'd2, 1'b1, 4'hF, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 1);
    // sh upper half.
    access(3'b100, 32'h0000_000A, 32'hAAAA_BBBB, 2, 32'h0, 1'b1,
           10'd2, 1'b1, 4'hC, 32'hBBBB_0000, 32'hCAFE_F00D, 1'b0, 1'b0, 3, 2);
    // sh lower half.
    access(3'b100, 32'h0000_0004, 32'h1111_2222, 1, 32'h0, 1'b1,
           10'd1, 1'b1, 4'h3, 32'h0000_2222, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 1);
    // lw with no ack: timeout after TIMEOUT request cycles.
    access(3'b011, 32'h0000_003C, 32'h0, 0, 32'h0, 1'b1,
           10'hF, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 5, 4);
    // Read and write both asserted: read only.
    access(3'b001, 32'h0000_0040, 32'h9999_9999, 2, 32'h5555_AAAA, 1'b1,
           10'h10, 1'b0, 4'hF, 32'h0, 32'h5555_AAAA, 1'b0, 1'b0, 3, 2);
    // Upper address bits discarded.
    access(3'b011, 32'hFFFF_F004, 32'h0, 1, 32'h7777_0001, 1'b1,
           10'd1, 1'b0, 4'hF, 32'h0, 32'h7777_0001, 1'b0, 1'b0, 2, 1);
    // Misaligned word store.
`ifdef MEM_ALIGN_CHK_EN
    access(3'b101, 32'h0000_0006, 32'hA5A5_5A5A, 1, 32'h0, 1'b0,
           10'd0, 1'b0, 4'h0, 32'h0, 32'h7777_0001, 1'b0, 1'b1, 1, 0);
`else
    access(3'b101, 32'h0000_0006, 32'hA5A5_5A5A, 1, 32'h0, 1'b1,
           10'd1, 1'b1, 4'hF, 32'hA5A5_5A5A, 32'h7777_0001, 1'b0, 1'b0, 2, 1);
`endif

    // No-op plus a stray ack in IDLE.
    @(posedge clk); #1;
    ctrl_MEM = 3'b111; rdata_v = 32'hDEAD_DEAD; stray = 1'b1;
    chk("noop_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    stray = 1'b0;
    @(posedge clk); #1;
    chk("stray_ack_req", 32'(mem_req), 32'h0);
    chk("stray_ack_rd", dato_rd, 32'h7777_0001);
    chk("stray_ack_stall", 32'(stall), 32'h0);

    // Async reset in the middle of a request.
    @(posedge clk); #1;
    begin
      bus_exp_t b;
      b.addr = 10'd8; b.we = 1'b0; b.be = 4'hF; b.wdata = 32'h0;
      bus_q.push_back(b);
    end
    ack_at = 0;
    ctrl_MEM = 3'b011; alu_res = 32'h0000_0020;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_req_high", 32'(mem_req), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'h0);
    chk("async_rst_stall", 32'(stall), 32'h0);
    ctrl_MEM = 3'b111;
    @(posedge clk); #1;
    reset_n = 1'b1;
    access(3'b011, 32'h0000_0024, 32'h0, 1, 32'h0BAD_BEEF, 1'b1,
           10'd9, 1'b0, 4'hF, 32'h0, 32'h0BAD_BEEF, 1'b0, 1'b0, 2, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    chk("timeout_pulses", 32'(to_cnt), 32'h1);
`ifdef MEM_ALIGN_CHK_EN
    chk("align_pulses", 32'(al_cnt), 32'h1);
`else
    chk("align_pulses", 32'(al_cnt), 32'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
